// File: rtl/dly_arb_pkg.sv
// Shared types and sizing helpers for the dly_arb_ctrl arbiter/sequencer.
// Lock-state encoding is only consumed when DLY_ARB_LOCK_EN is defined.
package dly_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    function automatic int unsigned idw_of(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int unsigned cw_of(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/dly_arb_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its encoded index.
module dly_arb_rr
    import dly_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int unsigned off = 0; off < NREQ; off++) begin
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
        end
    end

endmodule

// File: rtl/dly_arb_ctrl.sv
// Round-robin arbiter feeding a fixed-latency tagged delay pipeline with an
// in-flight counter and flush. Define DLY_ARB_LOCK_EN for burst-lock support.
module dly_arb_ctrl
    import dly_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned LAT   = 3,
    localparam int unsigned IDW   = idw_of(NREQ),
    localparam int unsigned CW    = cw_of(LAT)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_vld,
`ifdef DLY_ARB_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    input  logic [NREQ*WIDTH-1:0] req_dat,
    output logic [NREQ-1:0]       req_rdy,
    input  logic                  flush,
    output logic                  rsp_vld,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_dat,
    output logic                  busy,
    output logic [CW-1:0]         inflight
);

    typedef struct packed {
        logic             vld;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] dat;
    } stage_t;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick_idx;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic             issue;
    logic [WIDTH-1:0] issue_dat;
    stage_t           stg [LAT];

`ifdef DLY_ARB_LOCK_EN
    lock_state_t      state, state_nxt;
    logic [IDW-1:0]   owner, owner_nxt;

    // While locked, non-owners are masked even if the owner is momentarily idle.
    always_comb begin
        elig = req_vld;
        if (state == LOCKED) begin
            elig = req_vld & (NREQ'(1) << owner);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            UNLOCKED: begin
                if (issue && req_lock[pick_idx]) begin
                    state_nxt = LOCKED;
                    owner_nxt = pick_idx;
                end
            end
            LOCKED: begin
                if (flush || !req_vld[owner] || (issue && !req_lock[owner])) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end
`else
    assign elig = req_vld;
`endif

    dly_arb_rr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx)
    );

    assign req_rdy   = grant & {NREQ{~flush & rstn}};
    assign issue     = |req_rdy;
    assign issue_dat = req_dat[pick_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
        end
    end

    // Only valid bits are reset; id/dat payload simply follows the shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                stg[k].vld <= 1'b0;
            end
        end else begin
            stg[0] <= '{vld: issue, id: pick_idx, dat: issue_dat};
            for (int unsigned k = 1; k < LAT; k++) begin
                stg[k] <= stg[k-1];
            end
            if (flush) begin
                for (int unsigned k = 0; k < LAT; k++) begin
                    stg[k].vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else if (issue && !rsp_vld) begin
            inflight <= inflight + CW'(1);
        end else if (!issue && rsp_vld) begin
            inflight <= inflight - CW'(1);
        end
    end

    assign rsp_vld = stg[LAT-1].vld;
    assign rsp_id  = stg[LAT-1].id;
    assign rsp_dat = stg[LAT-1].dat;
    assign busy    = (inflight != '0);

endmodule
